reset_seq: RTL and testbench

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/sync2.sv | 22 ++
 rtl/reset_seq.sv | 100 ++++++++++
 tb/tb_reset_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

  // Sequencer phases: wait for lock, prove lock stable, hold reset, run.
  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_HOLD   = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam int unsigned LOSS_W = 8;

  // Width of a counter that must reach max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 32'd2) ? 32'd1 : 32'($clog2(m));
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(32'd1024, 32'd16);

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for a stable PLL lock, holds downstream reset,
// then releases it; re-enters reset on lock loss or a soft request.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              rst_req,
  output logic              rst_out,
  output logic              ready,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int unsigned     CNT_W       = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX   = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;

  sync2 u_sync_lock (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Sequencer FSM; rst_out/ready are flops that always mirror (state != S_RUN),
  // so they change only on the edges that enter or leave S_RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_WAIT;
      cnt           <= '0;
      lock_loss_cnt <= '0;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          cnt <= '0;
          if (locked_s) state <= S_STABLE;
        end
        S_STABLE: begin
          if (!locked_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else if (rst_req) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            state   <= S_RUN;
            cnt     <= '0;
            rst_out <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // Lock loss outranks a simultaneous soft request.
          if (!locked_s) begin
            state   <= S_WAIT;
            cnt     <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
            if (lock_loss_cnt != LOSS_MAX) lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
          end else if (rst_req) begin
            state   <= S_HOLD;
            cnt     <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= S_WAIT;
          cnt     <= '0;
          rst_out <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq with a time-based reference model.
module tb_reset_seq;

  localparam int unsigned S = 8;
  localparam int unsigned H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       rst_req;
  logic       rst_out;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  always #5 clk = ~clk;

  reset_seq #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .rst_req       (rst_req),
    .rst_out       (rst_out),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  typedef struct {
    logic       rst_out;
    logic       ready;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n;
  int   hi;

  // Reference model: the release edge is computed from when lock was first
  // seen, pushed out by soft requests; lock counts as seen two edges late.
  int edge_no = 0;
  int rel     = 0;
  bit act     = 1'b0;
  bit h1      = 1'b0;
  bit h2      = 1'b0;
  int loss    = 0;

  always @(posedge clk) begin : model
    exp_t x;
    bit   ls;
    edge_no++;
    if (rst) begin
      h1   = 1'b0;
      h2   = 1'b0;
      act  = 1'b0;
      loss = 0;
    end else begin
      ls = h2;
      if (!ls) begin
        if (act && edge_no > rel) loss = (loss >= 255) ? 255 : loss + 1;
        act = 1'b0;
      end else if (!act) begin
        act = 1'b1;
        rel = edge_no + int'(S) + int'(H);
      end else if (rst_req && edge_no > rel - int'(H)) begin
        rel = edge_no + int'(H);
      end
      h2 = h1;
      h1 = pll_locked;
    end
    x.rst_out = !(act && edge_no >= rel);
    x.ready   = !x.rst_out;
    x.cnt     = 8'(loss);
    sb.push_back(x);
  end

  // Monitor: compare every cycle's outputs against the queued expectation.
  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expectation queued at %0t", $time);
    end else begin
      x = sb.pop_front();
      if (rst_out !== x.rst_out || ready !== x.ready || lock_loss_cnt !== x.cnt) begin
        bad++;
        $display("FAIL cycle_out @%0t: got rst_out=%b ready=%b cnt=%0d, want rst_out=%b ready=%b cnt=%0d",
                 $time, rst_out, ready, lock_loss_cnt, x.rst_out, x.ready, x.cnt);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Edges after the first one that samples the new pll value until ready rises.
  task automatic wait_ready(output int edges);
    edges = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        edges = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    rst_req    = 1'b0;
    cyc(3);
    check("reset_rst_out", int'(rst_out), 1);
    check("reset_ready", int'(ready), 0);
    check("reset_cnt", int'(lock_loss_cnt), 0);
    rst = 1'b0;
    cyc(2);

    // Test 1: release latency from first lock sample
    pll_locked = 1'b1;
    wait_ready(n);
    check("t1_latency", n, 14);

    // Test 2: one-cycle lock glitch while stable count is 5
    rst = 1'b1;
    pll_locked = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    pll_locked = 1'b1;
    cyc(6);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    wait_ready(n);
    check("t2_restart_latency", n, 14);
    check("t2_loss_cnt", int'(lock_loss_cnt), 0);

    // Test 3: lock loss in run
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_rst_out_3edges", int'(rst_out), 1);
    @(negedge clk);
    check("t3_loss_cnt", int'(lock_loss_cnt), 1);
    cyc(3);
    pll_locked = 1'b1;
    wait_ready(n);
    check("t3_relock_latency", n, 14);

    // Test 4: single-cycle soft reset request in run
    rst_req = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) rst_req = 1'b0;
      if (rst_out) hi++;
      else if (hi > 0) break;
    end
    @(negedge clk);
    check("t4_hold_cycles", hi, 4);
    check("t4_loss_cnt", int'(lock_loss_cnt), 1);

    // Test 6: soft request and lock loss land on the same edge
    pll_locked = 1'b0;
    cyc(2);
    rst_req = 1'b1;
    cyc(1);
    rst_req = 1'b0;
    check("t6_loss_cnt", int'(lock_loss_cnt), 2);
    check("t6_rst_out", int'(rst_out), 1);
    cyc(2);
    pll_locked = 1'b1;
    wait_ready(n);
    check("t6_relock_latency", n, 14);

    // Test 5: saturate the loss counter, then reset mid-run
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      cyc(4);
      pll_locked = 1'b1;
      wait_ready(n);
      if (n < 0) check("t5_relock_timeout", n, 14);
    end
    check("t5_saturated", int'(lock_loss_cnt), 255);
    check("t5_ready_before_rst", int'(ready), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_rst_out", int'(rst_out), 1);
    check("t5_rst_ready", int'(ready), 0);
    check("t5_rst_cnt", int'(lock_loss_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Random bursts of lock, glitches, soft requests and resets
    for (int b = 0; b < 150; b++) begin
      int len;
      pll_locked = 1'b1;
      len = int'($urandom_range(5, 40));
      for (int c = 0; c < len; c++) begin
        rst_req = ($urandom_range(0, 9) == 0);
        rst     = ($urandom_range(0, 99) == 0);
        cyc(1);
      end
      rst_req    = 1'b0;
      rst        = 1'b0;
      pll_locked = 1'b0;
      cyc(int'($urandom_range(1, 4)));
    end

    cyc(2);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
